// File: rtl/wf_gather_cnt_pkg.sv
// Shared constants and elaboration helpers for the warp gather counter.
package wf_gather_cnt_pkg;

   localparam int NUM_WARP_DEF = 16;
   localparam int CNT_W_DEF    = 3;
   localparam int TARGET_DEF   = 4;
   localparam int WID_W        = $clog2(NUM_WARP_DEF);

   function automatic int wid_width(input int num_warp);
      return (num_warp > 1) ? $clog2(num_warp) : 1;
   endfunction

   // A gather target must be reachable and must fit in the count field.
   function automatic bit target_ok(input int target, input int cnt_w);
      return (target >= 1) && (target <= (1 << cnt_w) - 1);
   endfunction

endpackage

// File: rtl/wf_gather_cnt_ext.sv
// Count table: 1R1W array with a registered read address and unreset contents.
module wf_gather_cnt_ext
   import wf_gather_cnt_pkg::*;
#(
   parameter int DEPTH = NUM_WARP_DEF,
   parameter int W     = CNT_W_DEF,
   parameter int AW    = wid_width(NUM_WARP_DEF)
) (
   input  logic          clock,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] addr_q;

   // Reading through the held address means a write landing on the same
   // edge as the address capture is seen by the next read.
   always_ff @(posedge clock) begin
      if (rd_en) addr_q <= rd_addr;
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[addr_q];

endmodule

// File: rtl/wf_gather_cnt_ctrl.sv
// Per-warp arrival counter: two-stage read/modify/write pipeline that raises a
// done handshake when a slot collects TARGET arrivals.
module wf_gather_cnt_ctrl
   import wf_gather_cnt_pkg::*;
#(
   parameter int NUM_WARP = NUM_WARP_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int TARGET   = TARGET_DEF,
   localparam int WW      = wid_width(NUM_WARP)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [WW-1:0] req_wid,
   input  logic          req_clr,
   output logic          done_valid,
   input  logic          done_ready,
   output logic [WW-1:0] done_wid,
   output logic          busy
);

   if (!target_ok(TARGET, CNT_W)) begin : g_bad_target
      $error("wf_gather_cnt_ctrl: TARGET out of range for CNT_W");
   end

   localparam logic [CNT_W-1:0] TGT = CNT_W'(TARGET);

   logic [NUM_WARP-1:0] live;
   logic                s1_valid;
   logic [WW-1:0]       s1_wid;
   logic                s1_clr;
   logic [CNT_W-1:0]    rd_data;
   logic [CNT_W-1:0]    old_cnt;
   logic [CNT_W-1:0]    new_cnt;
   logic                stall;
   logic                accept;
   logic                s1_go;
   logic                hit;
   logic                wr_en;

   assign stall     = done_valid && !done_ready;
   assign req_ready = !(s1_valid && stall);
   assign accept    = req_valid && req_ready;
   assign s1_go     = s1_valid && !stall;

   // A dead slot reads as zero whatever stale value the table holds.
   assign old_cnt = live[s1_wid] ? rd_data : '0;
   assign new_cnt = old_cnt + CNT_W'(1);
   assign hit     = s1_go && !s1_clr && (new_cnt == TGT);
   assign wr_en   = s1_go && !s1_clr && (new_cnt != TGT);
   assign busy    = s1_valid || done_valid;

   wf_gather_cnt_ext #(
      .DEPTH (NUM_WARP),
      .W     (CNT_W),
      .AW    (WW)
   ) u_table (
      .clock   (clock),
      .rd_en   (accept),
      .rd_addr (req_wid),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_addr (s1_wid),
      .wr_data (new_cnt)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         live       <= '0;
         s1_valid   <= 1'b0;
         s1_wid     <= '0;
         s1_clr     <= 1'b0;
         done_valid <= 1'b0;
         done_wid   <= '0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
            s1_wid   <= req_wid;
            s1_clr   <= req_clr;
         end else if (!stall) begin
            s1_valid <= 1'b0;
         end

         if (s1_go) live[s1_wid] <= !(s1_clr || hit);

         // hit implies the register is empty or draining this edge.
         if (hit) begin
            done_valid <= 1'b1;
            done_wid   <= s1_wid;
         end else if (done_ready) begin
            done_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wf_gather_cnt_ctrl.sv
// Bench for wf_gather_cnt_ctrl: directed gather scenarios plus a random phase,
// with a behavioural count model feeding an expected-done queue.
module tb_wf_gather_cnt_ctrl;

   localparam int NW  = 16;
   localparam int WW  = 4;
   localparam int TGT = 4;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          req_valid;
   logic          req_ready;
   logic [WW-1:0] req_wid;
   logic          req_clr;
   logic          done_valid;
   logic          done_ready;
   logic [WW-1:0] done_wid;
   logic          busy;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   bit            chk_lat  = 1'b1;
   bit            rand_bp  = 1'b0;
   int            model_cnt [NW];
   logic [WW-1:0] exp_q [$];
   int            cyc_q [$];

   wf_gather_cnt_ctrl #(.NUM_WARP(NW), .CNT_W(3), .TARGET(TGT)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wid    (req_wid),
      .req_clr    (req_clr),
      .done_valid (done_valid),
      .done_ready (done_ready),
      .done_wid   (done_wid),
      .busy       (busy)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      if (rand_bp) begin
         #1;
         done_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- scoreboard ----------------
   // Sampled mid-cycle: a request seen valid&&ready here is taken at the next edge.
   always @(negedge clock) begin
      if (!reset_n) begin
         exp_q.delete();
         cyc_q.delete();
         foreach (model_cnt[i]) model_cnt[i] = 0;
      end else begin
         if (done_valid && done_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'(done_wid) + 32'd1000, 32'd0);
            end else begin
               check("done_wid", 32'(done_wid), 32'(exp_q.pop_front()));
               if (chk_lat) check("done_latency", cyc, cyc_q[0]);
               void'(cyc_q.pop_front());
            end
         end
         if (req_valid && req_ready) begin
            if (req_clr) begin
               model_cnt[req_wid] = 0;
            end else if (model_cnt[req_wid] + 1 == TGT) begin
               model_cnt[req_wid] = 0;
               exp_q.push_back(req_wid);
               cyc_q.push_back(cyc + 2);
            end else begin
               model_cnt[req_wid] = model_cnt[req_wid] + 1;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input int wid, input bit clr);
      int n;
      req_valid = 1'b1;
      req_wid   = WW'(wid);
      req_clr   = clr;
      n = 0;
      @(negedge clock);
      while (!req_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!req_ready) check("send_timeout", 32'd0, 32'd1);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic send_n(input int wid, input int cnt);
      for (int i = 0; i < cnt; i++) send(wid, 1'b0);
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) @(posedge clock);
      #1;
   endtask

   task automatic drain(input string tag);
      idle(8);
      check(tag, exp_q.size(), 32'd0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle(3);
      reset_n = 1'b1;
      @(negedge clock);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_done_valid", done_valid, 1'b0);
      check("rst_done_wid", done_wid, 32'd0);
      check("rst_busy", busy, 1'b0);
      @(posedge clock);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      req_valid  = 1'b0;
      req_wid    = '0;
      req_clr    = 1'b0;
      done_ready = 1'b1;
      reset_n    = 1'b0;
      foreach (model_cnt[i]) model_cnt[i] = 0;
      idle(2);
      do_reset();

      // four back-to-back increments of one slot
      send_n(5, 4);
      drain("t1_pending");

      // interleaved slots, then a partial restart that must stay silent
      for (int i = 0; i < 4; i++) begin
         send(2, 1'b0);
         send(3, 1'b0);
      end
      drain("t2_pending");
      send_n(2, 3);
      drain("t2_restart_pending");

      // clear in the middle of a gather
      send_n(7, 3);
      send(7, 1'b1);
      send_n(7, 3);
      drain("t3_no_early_done");
      send(7, 1'b0);
      drain("t3_pending");

      // backpressure with a second completion queued in S1
      chk_lat = 1'b0;
      send_n(4, 3);
      done_ready = 1'b0;
      send_n(1, 4);
      send(4, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("bp_done_valid", done_valid, 1'b1);
         check("bp_done_wid", 32'(done_wid), 32'd1);
         check("bp_req_ready", req_ready, 1'b0);
         check("bp_busy", busy, 1'b1);
      end
      @(posedge clock);
      #1;
      done_ready = 1'b1;
      @(negedge clock);
      check("bp_first_wid", 32'(done_wid), 32'd1);
      check("bp_ready_back", req_ready, 1'b1);
      @(negedge clock);
      check("bp_second_valid", done_valid, 1'b1);
      check("bp_second_wid", 32'(done_wid), 32'd4);
      @(posedge clock);
      #1;
      drain("t4_pending");
      chk_lat = 1'b1;

      // reset while S1 holds a completing increment
      send_n(9, 4);
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
      @(negedge clock);
      check("rst_mid_done_valid", done_valid, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      @(posedge clock);
      #1;
      drain("t5_no_done_after_reset");
      send_n(9, 4);
      drain("t5_pending");

      // random traffic with random consumer backpressure
      chk_lat = 1'b0;
      rand_bp = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send($urandom_range(0, 3), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      rand_bp = 1'b0;
      @(posedge clock);
      #2;
      done_ready = 1'b1;
      drain("rand_pending");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wf_gather_cnt_ctrl.md
WF_GATHER_CNT_CTRL -- requirements
Module: wf_gather_cnt_ctrl

Interface
REQ-001 SHALL have parameter NUM_WARP, default 16: number of warp slots (count-table depth).
REQ-002 SHALL have parameter CNT_W, default 3: count width in bits.
REQ-003 SHALL have parameter TARGET, default 4: arrivals per gather; legal range 1..(2^CNT_W-1), out-of-range rejected at elaboration.
REQ-004 SHALL have one clock and a synchronous, active-low reset.
REQ-005 clock  in  1  sole clock; all state on rising edge.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request accepted when valid&&ready.
REQ-009 req_wid  in  log2(NUM_WARP)  target warp slot.
REQ-010 req_clr  in  1  1 = clear slot count, 0 = increment.
REQ-011 done_valid  out  1  gather completed for done_wid.
REQ-012 done_ready  in  1  consumer takes done on valid&&ready.
REQ-013 done_wid  out  log2(NUM_WARP)  completed warp slot.
REQ-014 busy  out  1  S1 occupied or done_valid high.

Function
REQ-015 Two-stage pipeline: S0 accepts request, issues table read; S1 gets read data, computes, writes back.
REQ-016 Table read: registered address, data valid one cycle after read enable; read enable asserted only on accept, so the address holds while S1 is stalled.
REQ-017 Table write in S1 visible to a read accepted in the same cycle: back-to-back increments of one wid SHALL count exactly, no lost updates.
REQ-018 Per-slot live bit vector (NUM_WARP bits): live=0 makes the slot count read as 0 regardless of table contents.
REQ-019 Increment in S1: new = old+1, width CNT_W.
- new < TARGET: write new, set live bit.
- new == TARGET: clear live bit, load done register with wid.
REQ-020 Clear in S1: clear live bit, no done.
REQ-021 Latency: request accepted in cycle t completes S1 in t+1; done_valid high from t+2 when TARGET reached.
REQ-022 done_valid/done_wid held stable until done_ready; done register refills the same cycle it drains (no bubble).
REQ-023 Stall rule: stall = done_valid && !done_ready.
- S1 holds contents, performs no table write or live update while stalled.
- req_ready = !(s1_valid && stall).
REQ-024 Full throughput (one request per cycle) whenever done_ready is high.
REQ-025 Count never exceeds TARGET-1 in the table; no wrap-around is reachable.

Reset
REQ-026 reset_n low at a clock edge: live bits 0, s1_valid 0, done_valid 0, done_wid 0.
REQ-027 req_ready is 1 in the first cycle after reset deasserts.
REQ-028 Table contents are not reset; live bits make stale data invisible.
REQ-029 Reset mid-operation discards the in-flight S1 request and any pending done; no done after reset.

Structure
REQ-030 Shared package holds WID_W = log2(NUM_WARP), CNT_W default and the TARGET legality check.
REQ-031 One sub-module: wf_gather_cnt_ext (NUM_WARP x CNT_W, 1R1W, registered read address) as the count table; live bits, pipeline and done register in this module.

Verification
REQ-032 Reset, then 4 increments wid 5 on consecutive cycles, done_ready=1 -> exactly one done, wid 5, 2 cycles after 4th accept.
REQ-033 Interleaved increments wid 2/wid 3, each x4 -> done wid 2 then wid 3, no extra dones; next 3 increments wid 2 produce no done (count restarted at 0).
REQ-034 3 increments wid 7, clear wid 7, 4 increments wid 7 -> done only after the 4th post-clear increment.
REQ-035 done_ready=0 while dones for wids 1 and 4 complete -> done holds wid 1, req_ready drops with S1 full; done_ready=1 -> wid 1 then wid 4 on consecutive cycles, no loss.
REQ-036 Reset asserted with S1 holding the completing increment of wid 9 -> no done after reset; 4 new increments wid 9 -> one done.
